pll_cfg_ctrl: RTL and testbench
===============================

PLL_CFG_CTRL -- requirements
Module: pll_cfg_ctrl

Interface
REQ-001 SHALL have generic CFG_BITS, default 24: length of the PLL serial configuration word.
REQ-002 SHALL have generic SCLK_HALF, default 4: clk_i cycles per SCLK half-period (range 1..255).
REQ-003 SHALL have generic RST_CYCLES, default 16: clk_i cycles RESETB is held low before shifting.
REQ-004 SHALL have generic LOCK_TMO, default 65535: maximum clk_i cycles spent waiting for LOCK.
REQ-005 SHALL have port clk_i  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rstn_i  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port req_i  in  1  start-reconfiguration strobe.
REQ-008 SHALL have port cfg_i  in  CFG_BITS  configuration word; sampled on an accepted req_i.
REQ-009 SHALL have port busy_o  out  1  high from an accepted req_i until done_o.
REQ-010 SHALL have port done_o  out  1  one-cycle pulse at the end of every sequence.
REQ-011 SHALL have port err_o  out  1  sticky lock-timeout flag; cleared by the next accepted req_i.
REQ-012 SHALL have port locked_o  out  1  synchronized, qualified PLL lock status.
REQ-013 SHALL have port rdata_o  out  CFG_BITS  word shifted out of the PLL (SDO) during the last sequence.
REQ-014 SHALL have ports pll_sclk_o, pll_sdi_o, pll_resetb_o (out, 1 each) and pll_sdo_i, pll_lock_i (in, 1 each), all wired to the PLL primitive.

Function
REQ-015 SHALL implement states IDLE, RST_HOLD, SHIFT, RELEASE, WAIT_LOCK, LOCKED and FAIL.
REQ-016 SHALL accept req_i only in IDLE, LOCKED or FAIL, and ignore it in all other states.
REQ-017 On an accepted req_i, SHALL latch cfg_i, clear err_o and locked_o, set busy_o, drive pll_resetb_o=0 and enter RST_HOLD.
REQ-018 In RST_HOLD, SHALL hold pll_resetb_o=0 for exactly RST_CYCLES cycles, then enter SHIFT.
REQ-019 In SHIFT, SHALL transmit CFG_BITS bits MSB first; for each bit, pll_sdi_o is valid with pll_sclk_o=0 for SCLK_HALF cycles, then pll_sclk_o=1 for SCLK_HALF cycles.
REQ-020 SHALL sample pll_sdo_i in the cycle pll_sclk_o rises and shift it into the readback register LSB-in.
REQ-021 SHALL copy the readback register to rdata_o on exit from SHIFT; rdata_o is otherwise stable.
REQ-022 SHIFT total duration SHALL be exactly CFG_BITS*2*SCLK_HALF cycles; pll_sclk_o SHALL return to 0 on exit.
REQ-023 In RELEASE (one cycle), SHALL drive pll_resetb_o=1, clear the timeout counter and enter WAIT_LOCK.
REQ-024 SHALL pass pll_lock_i through a 2-FF synchronizer; the lock is qualified when the synchronized value is high for 4 consecutive cycles.
REQ-025 In WAIT_LOCK, on a qualified lock, SHALL set locked_o=1, pulse done_o, clear busy_o and enter LOCKED.
REQ-026 In WAIT_LOCK, after LOCK_TMO cycles without a qualified lock, SHALL set err_o=1, drive pll_resetb_o=0, pulse done_o, clear busy_o and enter FAIL.
REQ-027 In LOCKED, if the synchronized lock goes low, SHALL clear locked_o in the next cycle and re-enter WAIT_LOCK with the counter cleared, with busy_o remaining 0 and no done_o on relock.
REQ-028 If a qualified lock and the timeout occur in the same cycle, the lock SHALL take priority.
REQ-029 In IDLE and FAIL, SHALL hold pll_sclk_o=0, pll_sdi_o=0 and pll_resetb_o=0.

Reset
REQ-030 While rstn_i=0, SHALL force state IDLE, all counters and shift registers to 0, pll_resetb_o=0, pll_sclk_o=0, pll_sdi_o=0, busy_o=0, done_o=0, err_o=0, locked_o=0 and rdata_o=0.
REQ-031 Reset asserted mid-sequence (any state) SHALL abort immediately to the REQ-030 values, with no done_o pulse.

Verification
REQ-032 Nominal case: CFG_BITS=24, SCLK_HALF=4, cfg_i=0xA5C30F, req_i pulse, PLL model asserts LOCK 100 cycles after RESETB rises -> SDI bit sequence equals 0xA5C30F MSB first, 24 SCLK pulses of 8 cycles each, done_o pulses once, locked_o=1, err_o=0.
REQ-033 Readback: PLL model returns 0x123456 on SDO -> rdata_o=0x123456 after SHIFT.
REQ-034 Timeout: LOCK_TMO=50 and LOCK held low -> err_o=1 and done_o pulse after 50 WAIT_LOCK cycles, pll_resetb_o=0 afterwards, locked_o=0; a new req_i clears err_o.
REQ-035 Glitch and loss: a 2-cycle LOCK pulse leaves locked_o=0; LOCK dropping while in LOCKED -> locked_o=0 within 3 cycles, relock without a done_o pulse.
REQ-036 Ignored request and reset: req_i during SHIFT leaves the sequence and the latched cfg unchanged; rstn_i=0 during SHIFT -> all outputs return to REQ-030 values the same cycle.

Source files
------------

// File: rtl/pll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// pll_cfg_ctrl
// Reconfiguration sequencer for a PLL primitive with a serial config port.
// A request holds the PLL in reset, shifts a configuration word in MSB
// first while reading the old word back from SDO, releases reset and waits
// for a qualified lock. The sequence ends either LOCKED or FAIL (lock timeout).
//
// Ports
//   clk_i, rstn_i      system clock, asynchronous active-low reset
//   req_i, cfg_i       start strobe and configuration word (sampled on accept)
//   busy_o             high from an accepted request until done_o
//   done_o             one-cycle pulse at the end of every sequence
//   err_o              sticky lock-timeout flag, cleared by the next request
//   locked_o           synchronized, qualified lock status
//   rdata_o            word read back from SDO during the last shift
//   pll_sclk_o, pll_sdi_o, pll_resetb_o, pll_sdo_i, pll_lock_i  PLL primitive
// ---------------------------------------------------------------------------
module pll_cfg_ctrl #(
    parameter int CFG_BITS   = 24,
    parameter int SCLK_HALF  = 4,
    parameter int RST_CYCLES = 16,
    parameter int LOCK_TMO   = 65535
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_i,
    input  logic [CFG_BITS-1:0] cfg_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                locked_o,
    output logic [CFG_BITS-1:0] rdata_o,
    output logic                pll_sclk_o,
    output logic                pll_sdi_o,
    output logic                pll_resetb_o,
    input  logic                pll_sdo_i,
    input  logic                pll_lock_i
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_HOLD  = 3'd1;
    localparam logic [2:0] S_SHIFT     = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_WAIT_LOCK = 3'd4;
    localparam logic [2:0] S_LOCKED    = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    // One counter serves both the reset hold and the lock timeout.
    localparam int CNT_MAX = (LOCK_TMO > RST_CYCLES) ? LOCK_TMO : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = $clog2(2 * SCLK_HALF);
    localparam int BIT_W   = $clog2(CFG_BITS + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCLK_HALF);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [PH_W-1:0]     phase;
    logic [BIT_W-1:0]    bit_idx;
    logic [CFG_BITS-1:0] tx_sr;
    logic [CFG_BITS-1:0] rx_sr;
    logic [CFG_BITS-1:0] rx_next;
    logic                lock_meta;
    logic                lock_sync;
    logic [2:0]          lock_hist;
    logic                lock_qual;
    logic                req_ok;

    // Lock synchronizer plus a history of the last three synchronized
    // samples; together with the current one that gives four in a row.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_hist <= '0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_sync <= lock_meta;
            lock_hist <= {lock_hist[1:0], lock_sync};
        end
    end

    assign lock_qual = lock_sync & (&lock_hist);

    assign req_ok = req_i && ((state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL));

    // SDO is captured in the first cycle of each high SCLK half. The final
    // capture can coincide with leaving SHIFT (SCLK_HALF=1), so rdata_o is
    // loaded from this next-value rather than from rx_sr.
    assign rx_next = ((state == S_SHIFT) && (phase == PH_RISE)) ?
                     {rx_sr[CFG_BITS-2:0], pll_sdo_i} : rx_sr;

    // Sequencer. A request is only honoured in the resting states and
    // always restarts the full reset/shift/lock sequence.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            phase    <= '0;
            bit_idx  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rdata_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            rx_sr  <= rx_next;
            if (req_ok) begin
                tx_sr    <= cfg_i;
                rx_sr    <= '0;
                err_o    <= 1'b0;
                locked_o <= 1'b0;
                busy_o   <= 1'b1;
                cnt      <= '0;
                state    <= S_RST_HOLD;
            end else begin
                case (state)
                    S_RST_HOLD: begin
                        if (cnt == RST_LAST) begin
                            cnt     <= '0;
                            phase   <= '0;
                            bit_idx <= '0;
                            state   <= S_SHIFT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (phase == PH_LAST) begin
                            phase <= '0;
                            tx_sr <= {tx_sr[CFG_BITS-2:0], 1'b0};
                            if (bit_idx == BIT_LAST) begin
                                rdata_o <= rx_next;
                                state   <= S_RELEASE;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        cnt   <= '0;
                        state <= S_WAIT_LOCK;
                    end
                    S_WAIT_LOCK: begin
                        // Lock wins over a timeout in the same cycle. A relock
                        // after loss has busy_o low, so it produces no done_o.
                        if (lock_qual) begin
                            locked_o <= 1'b1;
                            done_o   <= busy_o;
                            busy_o   <= 1'b0;
                            state    <= S_LOCKED;
                        end else if (cnt == TMO_LAST) begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_FAIL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (!lock_sync) begin
                            locked_o <= 1'b0;
                            cnt      <= '0;
                            state    <= S_WAIT_LOCK;
                        end
                    end
                    S_IDLE, S_FAIL: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // PLL pins are decoded from state so an asynchronous reset drops them
    // immediately. RESETB is only released once the word is fully shifted.
    assign pll_sclk_o   = (state == S_SHIFT) && (phase >= PH_RISE);
    assign pll_sdi_o    = (state == S_SHIFT) && tx_sr[CFG_BITS-1];
    assign pll_resetb_o = (state == S_RELEASE) || (state == S_WAIT_LOCK) || (state == S_LOCKED);

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_cfg_ctrl
// Directed bench for pll_cfg_ctrl with a small PLL model (SDO readback word,
// lock after a delay, or manually driven lock). A sequence-level reference
// model predicts every output each cycle; literal checks pin the model.
// The lock timeout is 50 cycles, so the nominal PLL locks 30 cycles after
// RESETB rises to stay inside it.
// ---------------------------------------------------------------------------
module tb_pll_cfg_ctrl;

    localparam int W   = 24;
    localparam int H   = 4;
    localparam int R   = 16;
    localparam int TMO = 50;
    localparam int S   = W * 2 * H;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req = 1'b0;
    logic [W-1:0] cfg = '0;
    logic         busy_o, done_o, err_o, locked_o;
    logic [W-1:0] rdata_o;
    logic         pll_sclk_o, pll_sdi_o, pll_resetb_o;
    logic         pll_sdo_i = 1'b0;
    logic         pll_lock_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    pll_cfg_ctrl #(
        .CFG_BITS(W), .SCLK_HALF(H), .RST_CYCLES(R), .LOCK_TMO(TMO)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .cfg_i(cfg),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .locked_o(locked_o),
        .rdata_o(rdata_o), .pll_sclk_o(pll_sclk_o), .pll_sdi_o(pll_sdi_o),
        .pll_resetb_o(pll_resetb_o), .pll_sdo_i(pll_sdo_i), .pll_lock_i(pll_lock_i)
    );

    always #5 clk = ~clk;

    // Comparison helper: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PLL model: shifts the readback word out on SDO (next bit after each
    // SCLK fall) and asserts lock per lock_mode (0 auto, 1 never, 2 manual).
    logic [W-1:0] rb_word = 24'h123456;
    int           sdo_idx = 0;
    logic         pll_sclk_q = 1'b0;
    int           lock_mode = 0;
    int           lock_delay = 30;
    int           lock_cnt = 0;
    logic         manual_lock = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            sdo_idx = 0;
        end else if (!pll_sclk_o && pll_sclk_q) begin
            sdo_idx = (sdo_idx == W - 1) ? 0 : sdo_idx + 1;
        end
        pll_sclk_q = pll_sclk_o;
        pll_sdo_i  = rb_word[W-1-sdo_idx];
        if (lock_mode == 2) begin
            pll_lock_i = manual_lock;
        end else if (lock_mode == 1 || !pll_resetb_o) begin
            pll_lock_i = 1'b0;
            lock_cnt   = 0;
        end else if (lock_cnt >= lock_delay) begin
            pll_lock_i = 1'b1;
        end else begin
            lock_cnt++;
        end
    end

    // Monitor: cumulative counts used by the literal checks.
    int           done_cnt = 0;
    int           sclk_rises = 0;
    int           sclk_high = 0;
    logic         mon_sclk_q = 1'b0;
    logic [W-1:0] sdi_word = '0;

    always @(negedge clk) begin
        if (pll_sclk_o && !mon_sclk_q) begin
            sclk_rises++;
            sdi_word = {sdi_word[W-2:0], pll_sdi_o};
        end
        if (pll_sclk_o) sclk_high++;
        if (done_o) done_cnt++;
        mon_sclk_q = pll_sclk_o;
    end

    // Reference model. A sequence is timed by cycles elapsed since the
    // accepting edge: R cycles of reset hold, S cycles of shifting, one
    // release cycle, then waiting for lock. Lock is seen two cycles late
    // and qualified after four consecutive high samples.
    typedef enum {M_IDLE, M_SEQ, M_WAIT, M_LOCKED, M_FAIL} mmode_t;
    mmode_t       mode = M_IDLE;
    int           t = 0;
    int           wcnt = 0;
    logic [W-1:0] cfg_m = '0;
    logic [W-1:0] rx_m = '0;
    logic [W-1:0] m_rdata = '0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_locked = 1'b0;
    logic         lh [1:5];
    logic         qual, lost;

    assign qual = lh[2] & lh[3] & lh[4] & lh[5];
    assign lost = !lh[2];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode <= M_IDLE; t <= 0; wcnt <= 0; cfg_m <= '0; rx_m <= '0; m_rdata <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_locked <= 1'b0;
            for (int i = 1; i <= 5; i++) lh[i] <= 1'b0;
        end else begin
            m_done <= 1'b0;
            lh[1] <= pll_lock_i;
            for (int i = 2; i <= 5; i++) lh[i] <= lh[i-1];
            if (req && (mode == M_IDLE || mode == M_LOCKED || mode == M_FAIL)) begin
                mode <= M_SEQ; t <= 0; cfg_m <= cfg; rx_m <= '0;
                m_busy <= 1'b1; m_err <= 1'b0; m_locked <= 1'b0;
            end else begin
                case (mode)
                    M_SEQ: begin
                        if (t >= R && t < R + S && ((t - R) % (2 * H)) == H)
                            rx_m <= {rx_m[W-2:0], pll_sdo_i};
                        if (t == R + S - 1) m_rdata <= rx_m;
                        if (t == R + S) begin
                            mode <= M_WAIT; wcnt <= 0;
                        end else begin
                            t <= t + 1;
                        end
                    end
                    M_WAIT: begin
                        if (qual) begin
                            m_locked <= 1'b1; m_done <= m_busy; m_busy <= 1'b0; mode <= M_LOCKED;
                        end else if (wcnt == TMO - 1) begin
                            m_err <= 1'b1; m_done <= 1'b1; m_busy <= 1'b0; mode <= M_FAIL;
                        end else begin
                            wcnt <= wcnt + 1;
                        end
                    end
                    M_LOCKED: begin
                        if (lost) begin
                            m_locked <= 1'b0; mode <= M_WAIT; wcnt <= 0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Cycle compare of every output against the model, away from the edge.
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        logic e_sclk, e_sdi, e_resetb;
        bit   shifting;
        if (chk_en) begin
            shifting = (mode == M_SEQ) && (t >= R) && (t < R + S);
            e_sclk   = shifting && (((t - R) % (2 * H)) >= H);
            e_sdi    = shifting ? cfg_m[W-1-((t - R) / (2 * H))] : 1'b0;
            e_resetb = (mode == M_SEQ && t == R + S) || mode == M_WAIT || mode == M_LOCKED;
            checkOutput("busy",   32'(busy_o),       32'(m_busy));
            checkOutput("done",   32'(done_o),       32'(m_done));
            checkOutput("err",    32'(err_o),        32'(m_err));
            checkOutput("locked", 32'(locked_o),     32'(m_locked));
            checkOutput("rdata",  32'(rdata_o),      32'(m_rdata));
            checkOutput("sclk",   32'(pll_sclk_o),   32'(e_sclk));
            checkOutput("sdi",    32'(pll_sdi_o),    32'(e_sdi));
            checkOutput("resetb", 32'(pll_resetb_o), 32'(e_resetb));
        end
    end

    // One-cycle request pulse, driven just after a rising edge.
    task automatic applyStimulus(input logic [W-1:0] word);
        @(posedge clk); #1;
        req = 1'b1;
        cfg = word;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) checkOutput({name, "_done_wait"}, 32'(0), 32'(1));
    endtask

    task automatic waitResetbHigh(input string name, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!pll_resetb_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!pll_resetb_o) checkOutput({name, "_resetb_wait"}, 32'(0), 32'(1));
    endtask

    initial begin
        int d0, r0, h0, n, lc;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",   32'(busy_o),       32'(0));
        checkOutput("rst_done",   32'(done_o),       32'(0));
        checkOutput("rst_err",    32'(err_o),        32'(0));
        checkOutput("rst_locked", 32'(locked_o),     32'(0));
        checkOutput("rst_rdata",  32'(rdata_o),      32'(0));
        checkOutput("rst_sclk",   32'(pll_sclk_o),   32'(0));
        checkOutput("rst_sdi",    32'(pll_sdi_o),    32'(0));
        checkOutput("rst_resetb", 32'(pll_resetb_o), 32'(0));
        chk_en = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        // Nominal sequence with readback
        $display("[TB] nominal sequence");
        d0 = done_cnt; r0 = sclk_rises; h0 = sclk_high;
        applyStimulus(24'hA5C30F);
        checkOutput("nom_busy_after_req", 32'(busy_o), 32'(1));
        waitDone("nom", 600);
        @(negedge clk);
        checkOutput("nom_sdi_word",   32'(sdi_word),         32'h00A5C30F);
        checkOutput("nom_sclk_rises", 32'(sclk_rises - r0),  32'(24));
        checkOutput("nom_sclk_high",  32'(sclk_high - h0),   32'(96));
        checkOutput("nom_done_count", 32'(done_cnt - d0),    32'(1));
        checkOutput("nom_rdata",      32'(rdata_o),          32'h00123456);
        checkOutput("nom_locked",     32'(locked_o),         32'(1));
        checkOutput("nom_err",        32'(err_o),            32'(0));
        checkOutput("nom_busy",       32'(busy_o),           32'(0));

        // Request during SHIFT is ignored
        $display("[TB] ignored request");
        applyStimulus(24'h3C3C3C);
        repeat (R + 20) @(posedge clk);
        #1;
        req = 1'b1; cfg = 24'hFFFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        waitDone("ign", 600);
        @(negedge clk);
        checkOutput("ign_sdi_word", 32'(sdi_word), 32'h003C3C3C);
        checkOutput("ign_locked",   32'(locked_o), 32'(1));

        // Lock glitch, loss and relock
        $display("[TB] glitch and loss");
        lock_mode = 2; manual_lock = 1'b0;
        applyStimulus(24'h5A5A5A);
        waitResetbHigh("gl", 600);
        repeat (3) @(posedge clk);
        #1 manual_lock = 1'b1;
        repeat (2) @(posedge clk);
        #1 manual_lock = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch_locked", 32'(locked_o), 32'(0));
        checkOutput("glitch_busy",   32'(busy_o),   32'(1));
        @(posedge clk); #1 manual_lock = 1'b1;
        waitDone("gl", 40);
        @(negedge clk);
        checkOutput("gl_locked", 32'(locked_o), 32'(1));
        @(posedge clk); #1 manual_lock = 1'b0;
        @(negedge clk);
        lc = 0;
        while (locked_o && lc < 10) begin
            @(negedge clk);
            lc++;
        end
        checkOutput("loss_within_3", 32'(lc <= 3), 32'(1));
        checkOutput("loss_locked",   32'(locked_o), 32'(0));
        d0 = done_cnt;
        @(posedge clk); #1 manual_lock = 1'b1;
        n = 0;
        @(negedge clk);
        while (!locked_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("relock_locked", 32'(locked_o), 32'(1));
        @(negedge clk);
        checkOutput("relock_no_done", 32'(done_cnt - d0), 32'(0));
        checkOutput("relock_busy",    32'(busy_o),        32'(0));

        // Lock timeout
        $display("[TB] lock timeout");
        lock_mode = 1;
        applyStimulus(24'h000001);
        waitResetbHigh("tmo", 600);
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo_cycles", 32'(n),             32'(51));
        checkOutput("tmo_err",    32'(err_o),         32'(1));
        checkOutput("tmo_locked", 32'(locked_o),      32'(0));
        checkOutput("tmo_resetb", 32'(pll_resetb_o),  32'(0));
        repeat (5) @(negedge clk);
        checkOutput("tmo_err_sticky", 32'(err_o), 32'(1));
        lock_mode = 0;
        applyStimulus(24'h00FF00);
        checkOutput("new_req_clears_err", 32'(err_o), 32'(0));
        waitDone("rec", 600);
        @(negedge clk);
        checkOutput("rec_locked", 32'(locked_o), 32'(1));

        // Reset in the middle of SHIFT
        $display("[TB] reset during shift");
        applyStimulus(24'h0F0F0F);
        repeat (R + 30) @(posedge clk);
        d0 = done_cnt;
        #1 rstn = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy",   32'(busy_o),       32'(0));
        checkOutput("abort_sclk",   32'(pll_sclk_o),   32'(0));
        checkOutput("abort_sdi",    32'(pll_sdi_o),    32'(0));
        checkOutput("abort_resetb", 32'(pll_resetb_o), 32'(0));
        checkOutput("abort_rdata",  32'(rdata_o),      32'(0));
        checkOutput("abort_locked", 32'(locked_o),     32'(0));
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_cnt - d0), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
